// File: rtl/rgb_to_binary.sv
// RGB-to-binary converter: two-stage luma/threshold pipeline with valid/ready
// backpressure and raster position tracking (eol/eof flags, frame_done pulse).
module rgb_to_binary #(
  parameter int unsigned WIDTH  = 256,
  parameter int unsigned HEIGHT = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] threshold,
  output logic [7:0] out_gray,
  output logic [7:0] out_binary,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_eol,
  output logic       out_eof,
  output logic       frame_done
);

  localparam logic [15:0] COL_LAST = 16'(WIDTH - 1);
  localparam logic [15:0] ROW_LAST = 16'(HEIGHT - 1);

  logic        advance, accept, out_hs;
  logic        s1_valid_q;
  logic [7:0]  s1_luma_q, s1_luma_d;
  logic [7:0]  s1_thr_q;
  logic        out_valid_q;
  logic [7:0]  gray_q, gray_d;
  logic [7:0]  bin_q, bin_d;
  logic [15:0] col_q, col_d;
  logic [15:0] row_q, row_d;
  logic        frame_done_q, frame_done_d;
  logic        eol, eof;

  assign advance = !out_valid_q || out_ready;
  assign accept  = in_valid && advance;
  assign out_hs  = out_valid_q && out_ready;

  assign eol = out_valid_q && (col_q == COL_LAST);
  assign eof = eol && (row_q == ROW_LAST);

  // Only the high byte of the weighted sum is ever used, so stage 1 keeps just
  // that byte; the max sum (65280) fits in 16 bits before truncation.
  always_comb begin
    s1_luma_d = 8'((16'd77  * {8'd0, in_r}
                  + 16'd150 * {8'd0, in_g}
                  + 16'd29  * {8'd0, in_b}) >> 8);
    gray_d    = s1_luma_q;
    bin_d     = (gray_d >= s1_thr_q) ? 8'hFF : 8'h00;
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = out_hs && eof;
    if (out_hs) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 16'd1;
      end else begin
        col_d = col_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_luma_q   <= '0;
      s1_thr_q    <= '0;
      out_valid_q <= 1'b0;
      gray_q      <= '0;
      bin_q       <= '0;
    end else if (advance) begin
      s1_valid_q  <= accept;
      out_valid_q <= s1_valid_q;
      if (accept) begin
        s1_luma_q <= s1_luma_d;
        s1_thr_q  <= threshold;
      end
      if (s1_valid_q) begin
        gray_q <= gray_d;
        bin_q  <= bin_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready   = advance;
  assign out_valid  = out_valid_q;
  assign out_gray   = gray_q;
  assign out_binary = bin_q;
  assign out_eol    = eol;
  assign out_eof    = eof;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_rgb_to_binary.sv
// Directed + randomized bench for rgb_to_binary against a queue-based
// reference model (luma by plain arithmetic, raster position from pixel index).
module tb_rgb_to_binary;

  localparam int unsigned W = 4;
  localparam int unsigned H = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0, threshold = '0;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic       in_ready, out_valid, out_eol, out_eof, frame_done;
  logic [7:0] out_gray, out_binary;

  rgb_to_binary #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_valid(in_valid), .in_ready(in_ready), .threshold(threshold),
    .out_gray(out_gray), .out_binary(out_binary),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_eol(out_eol), .out_eof(out_eof), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] gray;
    logic [7:0] bin;
  } exp_t;

  exp_t       q[$];
  int         passed = 0, total = 0;
  int         idx = 0, accepted = 0, fd_count = 0;
  logic       fd_exp = 1'b0, prev_stall = 1'b0;
  logic [7:0] prev_gray = '0, prev_bin = '0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [7:0] r, g, b, thr);
    exp_t e;
    int   luma;
    luma   = (77 * int'(r) + 150 * int'(g) + 29 * int'(b)) / 256;
    e.gray = 8'(luma);
    e.bin  = (luma >= int'(thr)) ? 8'hFF : 8'h00;
    return e;
  endfunction

  task automatic observe();
    exp_t e;
    logic exp_eol, exp_eof;
    check("frame_done", {15'd0, frame_done}, {15'd0, fd_exp});
    fd_exp = 1'b0;
    if (frame_done === 1'b1) fd_count++;
    if (prev_stall) begin
      check("stall_valid", {15'd0, out_valid}, 16'd1);
      check("stall_gray", {8'd0, out_gray}, {8'd0, prev_gray});
      check("stall_bin", {8'd0, out_binary}, {8'd0, prev_bin});
    end
    if (out_valid === 1'b1) begin
      exp_eol = ((idx % W) == W - 1);
      exp_eof = exp_eol && (((idx / W) % H) == H - 1);
      check("eol", {15'd0, out_eol}, {15'd0, exp_eol});
      check("eof", {15'd0, out_eof}, {15'd0, exp_eof});
      if (!out_ready) begin
        check("stall_in_ready", {15'd0, in_ready}, 16'd0);
      end else begin
        check("out_expected", 16'(q.size() != 0), 16'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("gray", {8'd0, out_gray}, {8'd0, e.gray});
          check("binary", {8'd0, out_binary}, {8'd0, e.bin});
          idx++;
          fd_exp = exp_eof;
        end
      end
    end else begin
      check("eol_idle", {14'd0, out_eol, out_eof}, 16'd0);
      check("in_ready_idle", {15'd0, in_ready}, 16'd1);
    end
    prev_stall = out_valid && !out_ready;
    prev_gray  = out_gray;
    prev_bin   = out_binary;
    if (in_valid && in_ready) begin
      q.push_back(model(in_r, in_g, in_b, threshold));
      accepted++;
    end
  endtask

  // One clock cycle: drive just after a falling edge, observe, wait for the next.
  task automatic cycle(input logic iv, input logic [7:0] r, g, b, thr, input logic ordy);
    in_valid = iv; in_r = r; in_g = g; in_b = b; threshold = thr; out_ready = ordy;
    #1;
    observe();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 8'd0, 8'd0, 8'd128, 1'b1);
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && q.size() != 0; c++) idle(1);
    check("drain_empty", 16'(q.size()), 16'd0);
    idle(2);
  endtask

  initial begin
    int start, fd0;

    // Reset held for 3 cycles
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", {15'd0, out_valid}, 16'd0);
    check("rst_gray", {8'd0, out_gray}, 16'd0);
    check("rst_in_ready", {15'd0, in_ready}, 16'd1);
    check("rst_frame_done", {15'd0, frame_done}, 16'd0);
    rst_n = 1'b1;

    // Conversion values and 2-cycle latency
    cycle(1'b1, 8'd255, 8'd255, 8'd255, 8'd128, 1'b1);
    check("lat_cycle1", {15'd0, out_valid}, 16'd0);
    cycle(1'b1, 8'd0, 8'd0, 8'd0, 8'd128, 1'b1);
    check("lat_cycle2", {15'd0, out_valid}, 16'd1);
    check("lat_gray", {8'd0, out_gray}, 16'd255);
    cycle(1'b1, 8'd100, 8'd100, 8'd100, 8'd128, 1'b1);
    cycle(1'b1, 8'd255, 8'd0, 8'd0, 8'd128, 1'b1);
    cycle(1'b1, 8'd0, 8'd255, 8'd0, 8'd128, 1'b1);
    idle(3);

    // Threshold edges, then a threshold change right after acceptance
    cycle(1'b1, 8'd100, 8'd100, 8'd100, 8'd100, 1'b1);
    cycle(1'b1, 8'd100, 8'd100, 8'd100, 8'd101, 1'b1);
    cycle(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
    cycle(1'b1, 8'd100, 8'd100, 8'd100, 8'd200, 1'b1);
    cycle(1'b0, 8'd0, 8'd0, 8'd0, 8'd50, 1'b1);
    drain();

    // Backpressure: 8 pixels with a 5-cycle downstream stall
    start = accepted;
    for (int c = 0; c < 64 && (accepted - start) < 8; c++)
      cycle(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), !(c >= 3 && c < 8));
    check("bp_accepted", 16'(accepted - start), 16'd8);
    drain();

    // Asynchronous reset while a pixel is stalled at the output
    cycle(1'b1, 8'd200, 8'd200, 8'd200, 8'd10, 1'b0);
    cycle(1'b1, 8'd50, 8'd60, 8'd70, 8'd10, 1'b0);
    in_valid = 1'b0;
    check("pre_reset_valid", {15'd0, out_valid}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {15'd0, out_valid}, 16'd0);
    check("async_rst_gray", {8'd0, out_gray}, 16'd0);
    check("async_rst_bin", {8'd0, out_binary}, 16'd0);
    check("async_rst_in_ready", {15'd0, in_ready}, 16'd1);
    @(negedge clk);
    q.delete();
    idx = 0; fd_exp = 1'b0; prev_stall = 1'b0;
    rst_n = 1'b1;

    // Framing: two 4x2 frames streamed back-to-back
    fd0 = fd_count;
    for (int i = 0; i < 16; i++)
      cycle(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'd128, 1'b1);
    drain();
    check("frame_pixels", 16'(idx), 16'd16);
    check("frame_done_count", 16'(fd_count - fd0), 16'd2);

    // Random throttling over 3 frames
    start = accepted;
    fd0   = fd_count;
    for (int c = 0; c < 3000 && idx < 40; c++)
      cycle(((accepted - start) < 24) && ($urandom_range(0, 3) != 0),
            8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            $urandom_range(0, 2) != 0);
    drain();
    check("rand_pixels", 16'(idx), 16'd40);
    check("rand_frame_done_count", 16'(fd_count - fd0), 16'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
